// File: rtl/system_nios2_qsys_0_mult_iter_if.sv
// Bus bundle between a multiply requester (master) and the iterative
// multiplier cell (slave).
//   A_mul_start       master -> slave  request, operands sampled on acceptance
//   A_mul_flush       master -> slave  synchronous abort
//   A_mul_src1/src2   master -> slave  multiplicand / multiplier
//   A_mul_mode        master -> slave  00 MUL, 01 MULXSS, 10 MULXSU, 11 MULXUU
//   A_mul_busy        slave -> master  operation in progress
//   A_mul_done        slave -> master  one-cycle result-valid pulse
//   A_mul_cell_result slave -> master  registered result
// DATA_W must match the DATA_W of the attached multiplier.
interface system_nios2_qsys_0_mult_iter_if #(
    parameter int DATA_W = 32
);
    logic              A_mul_start;
    logic              A_mul_flush;
    logic [DATA_W-1:0] A_mul_src1;
    logic [DATA_W-1:0] A_mul_src2;
    logic [1:0]        A_mul_mode;
    logic              A_mul_busy;
    logic              A_mul_done;
    logic [DATA_W-1:0] A_mul_cell_result;

    modport master (
        output A_mul_start, A_mul_flush, A_mul_src1, A_mul_src2, A_mul_mode,
        input  A_mul_busy, A_mul_done, A_mul_cell_result
    );

    modport slave (
        input  A_mul_start, A_mul_flush, A_mul_src1, A_mul_src2, A_mul_mode,
        output A_mul_busy, A_mul_done, A_mul_cell_result
    );
endinterface

// File: rtl/system_nios2_qsys_0_mult_iter.sv
// Iterative multiplier: consumes SLICE_W bits of src2 per cycle (LSB slice
// first) and accumulates the exact 2*DATA_W-bit product, then returns the
// low half (MUL) or high half (MULX*) on A_mul_cell_result with a done pulse.
// Ports:
//   clk      single clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      slave side of system_nios2_qsys_0_mult_iter_if
// DATA_W must be an integer multiple of SLICE_W.
//
// state | meaning
// IDLE  | waiting for start
// ACC   | accumulating one src2 slice per cycle (busy)
// DONE  | result loaded, done pulse; a new start is accepted here
module system_nios2_qsys_0_mult_iter #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 16
) (
    input  logic clk,
    input  logic reset_n,
    system_nios2_qsys_0_mult_iter_if.slave bus
);
    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    // exact width of a signed (DATA_W+1) x (SLICE_W+1) partial product
    localparam int PP_W   = DATA_W + SLICE_W + 2;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t              state;
    logic [DATA_W-1:0]   src1_q;
    logic [DATA_W-1:0]   src2_q;
    logic [1:0]          mode_q;
    logic [2*DATA_W-1:0] acc;
    logic [CNT_W-1:0]    cnt;
    logic                busy_q;
    logic                done_q;
    logic [DATA_W-1:0]   result_q;

    logic                src1_signed;
    logic                src2_signed;
    logic                last_slice;
    logic [SLICE_W-1:0]  slice;
    logic [PP_W-1:0]     op1_x;
    logic [PP_W-1:0]     slice_x;
    logic [PP_W-1:0]     pp;
    logic [2*DATA_W-1:0] partial_base;
    logic [2*DATA_W-1:0] acc_next;

    always_comb begin
        src1_signed = (mode_q == 2'b01) || (mode_q == 2'b10);
        src2_signed = (mode_q == 2'b01);
        last_slice  = (cnt == CNT_W'(NSLICE - 1));
        // src2_q is shifted down each cycle, so the current slice is always at the bottom
        slice       = src2_q[SLICE_W-1:0];
        op1_x       = {{(SLICE_W + 2){src1_signed & src1_q[DATA_W-1]}}, src1_q};
        // only the most significant slice carries negative weight
        slice_x     = {{(DATA_W + 2){src2_signed & last_slice & slice[SLICE_W-1]}}, slice};
        pp          = op1_x * slice_x;
        acc_next    = acc + (partial_base << (SLICE_W * int'(cnt)));
    end

    generate
        if (PP_W >= 2 * DATA_W) begin : g_pp_trunc
            assign partial_base = pp[2*DATA_W-1:0];
        end else begin : g_pp_ext
            assign partial_base = {{(2 * DATA_W - PP_W){pp[PP_W-1]}}, pp};
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            src1_q   <= '0;
            src2_q   <= '0;
            mode_q   <= '0;
            acc      <= '0;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (bus.A_mul_flush) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.A_mul_start) begin
                        src1_q <= bus.A_mul_src1;
                        src2_q <= bus.A_mul_src2;
                        mode_q <= bus.A_mul_mode;
                        acc    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= ACC;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACC: begin
                    acc    <= acc_next;
                    src2_q <= src2_q >> SLICE_W;
                    cnt    <= cnt + 1'b1;
                    if (last_slice) begin
                        result_q <= (mode_q == 2'b00) ? acc_next[DATA_W-1:0]
                                                      : acc_next[2*DATA_W-1:DATA_W];
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.A_mul_busy        = busy_q;
    assign bus.A_mul_done        = done_q;
    assign bus.A_mul_cell_result = result_q;
endmodule

// File: tb/tb_system_nios2_qsys_0_mult_iter.sv
module tb_system_nios2_qsys_0_mult_iter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    system_nios2_qsys_0_mult_iter_if #(.DATA_W(32)) bus_a();
    system_nios2_qsys_0_mult_iter_if #(.DATA_W(32)) bus_b();

    system_nios2_qsys_0_mult_iter #(.DATA_W(32), .SLICE_W(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a)
    );
    system_nios2_qsys_0_mult_iter #(.DATA_W(32), .SLICE_W(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [31:0] s1, input logic [31:0] s2,
                                            input logic [1:0] m);
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] p;
        a = (m == 2'b01 || m == 2'b10) ? {{32{s1[31]}}, s1} : {32'h0, s1};
        b = (m == 2'b01) ? {{32{s2[31]}}, s2} : {32'h0, s2};
        p = a * b;
        return (m == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic op_a(input logic [31:0] s1, input logic [31:0] s2, input logic [1:0] m,
                        output logic [31:0] res, output int lat);
        @(negedge clk);
        bus_a.A_mul_start = 1'b1;
        bus_a.A_mul_src1  = s1;
        bus_a.A_mul_src2  = s2;
        bus_a.A_mul_mode  = m;
        @(negedge clk);
        bus_a.A_mul_start = 1'b0;
        lat = 0;
        while (bus_a.A_mul_done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = bus_a.A_mul_cell_result;
    endtask

    task automatic op_b(input logic [31:0] s1, input logic [31:0] s2, input logic [1:0] m,
                        output logic [31:0] res, output int lat);
        @(negedge clk);
        bus_b.A_mul_start = 1'b1;
        bus_b.A_mul_src1  = s1;
        bus_b.A_mul_src2  = s2;
        bus_b.A_mul_mode  = m;
        @(negedge clk);
        bus_b.A_mul_start = 1'b0;
        lat = 0;
        while (bus_b.A_mul_done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = bus_b.A_mul_cell_result;
    endtask

    task automatic test_reset();
        bus_a.A_mul_start = 1'b0; bus_a.A_mul_flush = 1'b0;
        bus_a.A_mul_src1 = '0; bus_a.A_mul_src2 = '0; bus_a.A_mul_mode = '0;
        bus_b.A_mul_start = 1'b0; bus_b.A_mul_flush = 1'b0;
        bus_b.A_mul_src1 = '0; bus_b.A_mul_src2 = '0; bus_b.A_mul_mode = '0;
        #12;
        checks++;
        if (bus_a.A_mul_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", bus_a.A_mul_busy);
        end
        checks++;
        if (bus_a.A_mul_done !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b expected 0", bus_a.A_mul_done);
        end
        checks++;
        if (bus_a.A_mul_cell_result !== 32'h0) begin
            errors++; $display("FAIL reset_result: got %h expected 0", bus_a.A_mul_cell_result);
        end
        checks++;
        if (bus_b.A_mul_cell_result !== 32'h0) begin
            errors++; $display("FAIL reset_result_b: got %h expected 0", bus_b.A_mul_cell_result);
        end
    endtask

    // start presented together with reset release, then cycle-by-cycle checks
    task automatic test_basic();
        @(negedge clk);
        reset_n = 1'b1;
        bus_a.A_mul_start = 1'b1;
        bus_a.A_mul_src1  = 32'h3;
        bus_a.A_mul_src2  = 32'h5;
        bus_a.A_mul_mode  = 2'b00;
        @(negedge clk);
        bus_a.A_mul_start = 1'b0;
        checks++;
        if (bus_a.A_mul_busy !== 1'b1 || bus_a.A_mul_done !== 1'b0) begin
            errors++; $display("FAIL basic_e0: got busy=%b done=%b expected busy=1 done=0",
                               bus_a.A_mul_busy, bus_a.A_mul_done);
        end
        @(negedge clk);
        checks++;
        if (bus_a.A_mul_busy !== 1'b1 || bus_a.A_mul_done !== 1'b0) begin
            errors++; $display("FAIL basic_e1: got busy=%b done=%b expected busy=1 done=0",
                               bus_a.A_mul_busy, bus_a.A_mul_done);
        end
        @(negedge clk);
        checks++;
        if (bus_a.A_mul_busy !== 1'b0 || bus_a.A_mul_done !== 1'b1) begin
            errors++; $display("FAIL basic_e2: got busy=%b done=%b expected busy=0 done=1",
                               bus_a.A_mul_busy, bus_a.A_mul_done);
        end
        checks++;
        if (bus_a.A_mul_cell_result !== 32'h0000000F) begin
            errors++; $display("FAIL basic_result: got %h expected 0000000f", bus_a.A_mul_cell_result);
        end
        @(negedge clk);
        checks++;
        if (bus_a.A_mul_done !== 1'b0 || bus_a.A_mul_cell_result !== 32'h0000000F) begin
            errors++; $display("FAIL basic_pulse: got done=%b result=%h expected done=0 result=0000000f",
                               bus_a.A_mul_done, bus_a.A_mul_cell_result);
        end
    endtask

    task automatic test_modes();
        logic [31:0] s1v [11];
        logic [31:0] s2v [11];
        logic [1:0]  mv  [11];
        logic [31:0] ev  [11];
        logic [31:0] res;
        int          lat;
        s1v = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
                32'hFFFFFFFE, 32'h12345678, 32'h00010000};
        s2v = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
                32'h00000003, 32'h00000010, 32'h00010000};
        mv  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b00,
                2'b01, 2'b00, 2'b11};
        ev  = '{32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE,
                32'h40000000, 32'hC0000000, 32'h40000000, 32'h00000000,
                32'hFFFFFFFF, 32'h23456780, 32'h00000001};
        for (int i = 0; i < 11; i++) begin
            op_a(s1v[i], s2v[i], mv[i], res, lat);
            checks++;
            if (lat !== 2) begin
                errors++; $display("FAIL modes_latency[%0d]: got %0d expected 2", i, lat);
            end
            checks++;
            if (res !== ev[i]) begin
                errors++; $display("FAIL modes_result[%0d]: got %h expected %h", i, res, ev[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus_a.A_mul_start = 1'b1;
        bus_a.A_mul_src1  = 32'h3;
        bus_a.A_mul_src2  = 32'h5;
        bus_a.A_mul_mode  = 2'b00;
        @(negedge clk);
        // start stays high while busy with different operands
        bus_a.A_mul_src1 = 32'h7;
        bus_a.A_mul_src2 = 32'h7;
        @(negedge clk);
        checks++;
        if (bus_a.A_mul_busy !== 1'b1) begin
            errors++; $display("FAIL b2b_busy: got %b expected 1", bus_a.A_mul_busy);
        end
        @(negedge clk);
        checks++;
        if (bus_a.A_mul_done !== 1'b1 || bus_a.A_mul_cell_result !== 32'h0000000F) begin
            errors++; $display("FAIL b2b_first: got done=%b result=%h expected done=1 result=0000000f",
                               bus_a.A_mul_done, bus_a.A_mul_cell_result);
        end
        bus_a.A_mul_src1 = 32'h6;
        bus_a.A_mul_src2 = 32'h9;
        @(negedge clk);
        bus_a.A_mul_start = 1'b0;
        checks++;
        if (bus_a.A_mul_busy !== 1'b1 || bus_a.A_mul_done !== 1'b0) begin
            errors++; $display("FAIL b2b_no_gap: got busy=%b done=%b expected busy=1 done=0",
                               bus_a.A_mul_busy, bus_a.A_mul_done);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus_a.A_mul_done !== 1'b1 || bus_a.A_mul_cell_result !== 32'h00000036) begin
            errors++; $display("FAIL b2b_second: got done=%b result=%h expected done=1 result=00000036",
                               bus_a.A_mul_done, bus_a.A_mul_cell_result);
        end
    endtask

    task automatic test_flush();
        int seen_done;
        @(negedge clk);
        bus_a.A_mul_start = 1'b1;
        bus_a.A_mul_src1  = 32'h10;
        bus_a.A_mul_src2  = 32'h10;
        bus_a.A_mul_mode  = 2'b00;
        @(negedge clk);
        bus_a.A_mul_start = 1'b0;
        bus_a.A_mul_flush = 1'b1;
        @(negedge clk);
        bus_a.A_mul_flush = 1'b0;
        checks++;
        if (bus_a.A_mul_busy !== 1'b0) begin
            errors++; $display("FAIL flush_busy: got %b expected 0", bus_a.A_mul_busy);
        end
        seen_done = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus_a.A_mul_done === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            errors++; $display("FAIL flush_no_done: got %0d done cycles expected 0", seen_done);
        end
        checks++;
        if (bus_a.A_mul_cell_result !== 32'h00000036) begin
            errors++; $display("FAIL flush_result: got %h expected 00000036", bus_a.A_mul_cell_result);
        end
        // flush wins over a simultaneous start
        bus_a.A_mul_start = 1'b1;
        bus_a.A_mul_flush = 1'b1;
        bus_a.A_mul_src1  = 32'h2;
        bus_a.A_mul_src2  = 32'h2;
        @(negedge clk);
        bus_a.A_mul_start = 1'b0;
        bus_a.A_mul_flush = 1'b0;
        checks++;
        if (bus_a.A_mul_busy !== 1'b0) begin
            errors++; $display("FAIL flush_priority: got busy=%b expected 0", bus_a.A_mul_busy);
        end
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus_a.A_mul_done === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done !== 0 || bus_a.A_mul_cell_result !== 32'h00000036) begin
            errors++; $display("FAIL flush_priority_done: got %0d done cycles result=%h expected 0 and 00000036",
                               seen_done, bus_a.A_mul_cell_result);
        end
    endtask

    task automatic test_reset_mid();
        int          seen_done;
        logic [31:0] res;
        int          lat;
        @(negedge clk);
        bus_a.A_mul_start = 1'b1;
        bus_a.A_mul_src1  = 32'h7;
        bus_a.A_mul_src2  = 32'h9;
        bus_a.A_mul_mode  = 2'b00;
        @(negedge clk);
        bus_a.A_mul_start = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus_a.A_mul_busy !== 1'b0 || bus_a.A_mul_done !== 1'b0 ||
            bus_a.A_mul_cell_result !== 32'h0) begin
            errors++; $display("FAIL rstmid_async: got busy=%b done=%b result=%h expected 0/0/0",
                               bus_a.A_mul_busy, bus_a.A_mul_done, bus_a.A_mul_cell_result);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus_a.A_mul_done === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done !== 0 || bus_a.A_mul_cell_result !== 32'h0) begin
            errors++; $display("FAIL rstmid_no_done: got %0d done cycles result=%h expected 0 and 0",
                               seen_done, bus_a.A_mul_cell_result);
        end
        op_a(32'h7, 32'h9, 2'b00, res, lat);
        checks++;
        if (res !== 32'h0000003F || lat !== 2) begin
            errors++; $display("FAIL rstmid_recover: got result=%h lat=%0d expected 0000003f lat=2", res, lat);
        end
    endtask

    task automatic test_slice8();
        logic [31:0] s1;
        logic [31:0] s2;
        logic [1:0]  m;
        logic [31:0] res;
        logic [31:0] exp_res;
        int          lat;
        for (int i = 0; i < 16; i++) begin
            if (i < 4) begin
                s1 = 32'hFFFFFFFF;
                s2 = 32'hFFFFFFFF;
                m  = 2'(i);
            end else begin
                s1 = $urandom;
                s2 = $urandom;
                m  = 2'($urandom_range(3, 0));
            end
            exp_res = ref_mul(s1, s2, m);
            op_b(s1, s2, m, res, lat);
            checks++;
            if (lat !== 4) begin
                errors++; $display("FAIL slice8_latency[%0d]: got %0d expected 4", i, lat);
            end
            checks++;
            if (res !== exp_res) begin
                errors++; $display("FAIL slice8_result[%0d]: %h x %h mode %0d got %h expected %h",
                                   i, s1, s2, m, res, exp_res);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_modes();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_slice8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
